// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch controller state (FETCH / HOLD / HALT)
//   WORD_W, PC_INC : datapath width and sequential PC step
//   DEF_*          : default values for the fetch_stage parameters
//   is_hlt()       : opcode match helper
package fetch_pkg;
  localparam int              WORD_W         = 16;
  localparam logic [WORD_W-1:0] PC_INC       = 16'd2;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;
  localparam logic [3:0]      DEF_HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {FETCH, HOLD, HALT} fetch_state_e;

  function automatic logic is_hlt(input logic [WORD_W-1:0] instr, input logic [3:0] op);
    return instr[WORD_W-1 -: 4] == op;
  endfunction
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer for a fetched instruction that could not enter IF/ID.
//   load     : capture in_instr/in_pc_plus2 and mark valid
//   unload   : entry consumed, clear valid
//   flush    : discard the entry (wins over load/unload)
//   valid, instr, pc_plus2 : buffered entry
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [WORD_W-1:0] in_pc_plus2,
  output logic              valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_plus2
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc_plus2 <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= in_instr;
      pc_plus2 <= in_pc_plus2;
    end else if (unload) begin
      valid    <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the variable-latency imem
// handshake, presents instructions to IF/ID, absorbs stalls through a
// one-entry hold buffer, takes ID redirects and stops on HLT.
//   clk, rst_n             : clock, synchronous active-low reset
//   imem_req/addr/rdy/data : instruction memory handshake
//   stall                  : IF/ID must not advance
//   redirect, redirect_pc  : taken branch/jump from ID
//   if_valid/instr/pc_plus2: IF/ID output register
//   pc, hlt                : current fetch PC, halted flag
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [3:0]        HLT_OPCODE = DEF_HLT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc_plus2,
  output logic [WORD_W-1:0] pc,
  output logic              hlt
);
  fetch_state_e      state;
  logic [WORD_W-1:0] req_addr;
  logic              drop;
  logic              out_open;
  logic              rsp_ok;
  logic              rsp_hlt;
  logic [WORD_W-1:0] rsp_pc2;
  logic              hb_load, hb_unload, hb_valid;
  logic [WORD_W-1:0] hb_instr, hb_pc2;

  // Request is forced low during the reset cycle so the memory sees no
  // request while it is being reset alongside us.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = req_addr;
  assign out_open  = !stall || !if_valid;
  assign rsp_pc2   = req_addr + PC_INC;
  assign rsp_hlt   = is_hlt(imem_data, HLT_OPCODE);
  assign rsp_ok    = (state == FETCH) && imem_rdy && !drop && !redirect;
  assign hb_load   = rsp_ok && !out_open;
  assign hb_unload = !redirect && (state == HOLD) && hb_valid && !stall;

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hb_load),
    .unload     (hb_unload),
    .flush      (redirect),
    .in_instr   (imem_data),
    .in_pc_plus2(rsp_pc2),
    .valid      (hb_valid),
    .instr      (hb_instr),
    .pc_plus2   (hb_pc2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus2 <= '0;
      hlt         <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      state    <= FETCH;
      hlt      <= 1'b0;
      // An in-flight request must finish at its old address; its response
      // is thrown away and only then does req_addr move to the new pc.
      if ((state == FETCH) && !imem_rdy) begin
        drop <= 1'b1;
      end else begin
        drop     <= 1'b0;
        req_addr <= redirect_pc;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_rdy && drop) begin
            drop     <= 1'b0;
            req_addr <= pc;
            if (out_open) if_valid <= 1'b0;
          end else if (imem_rdy) begin
            if (out_open) begin
              if_valid    <= 1'b1;
              if_instr    <= imem_data;
              if_pc_plus2 <= rsp_pc2;
            end
            if (rsp_hlt) begin
              // pc/req_addr stay on the HLT address
              state <= out_open ? HALT : HOLD;
              hlt   <= out_open;
            end else begin
              pc       <= rsp_pc2;
              req_addr <= rsp_pc2;
              if (!out_open) state <= HOLD;
            end
          end else if (out_open) begin
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          // if_valid is 1 here, so the output opens only on !stall
          if (!stall) begin
            if_valid    <= 1'b1;
            if_instr    <= hb_instr;
            if_pc_plus2 <= hb_pc2;
            if (is_hlt(hb_instr, HLT_OPCODE)) begin
              state <= HALT;
              hlt   <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (out_open) if_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
